// File: rtl/toggle_pulse_decoder.sv
// Receive end of a toggle-signalling link: synchronises a remote toggle level, emits one pulse per
// level change, queues events for a valid/ready consumer and keeps a wrapping event total.
// Optional sticky drop flag on ovf when TOGGLE_DEC_OVF_EN is defined; otherwise ovf is tied low.
module toggle_pulse_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PEND_W      = 4,
  parameter int unsigned COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tgl,
  output logic               pulse,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [PEND_W-1:0]  pending,
  output logic [COUNT_W-1:0] evt_cnt,
  output logic               ovf
);

  localparam int unsigned PrimeW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [0:0] {StPrime, StRun} state_e;

  state_e                   state_q, state_d;
  logic [PrimeW-1:0]        prime_cnt_q, prime_cnt_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     tgl_prev_q, tgl_prev_d;
  logic                     pulse_q, pulse_d;
  logic [PEND_W-1:0]        pending_q, pending_d;
  logic [COUNT_W-1:0]       cnt_q, cnt_d;
  logic                     tgl_s;
  logic                     tgl_edge;
  logic                     pop;
  logic                     pend_full;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPrime;
      prime_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  // Stay in prime long enough for the synchroniser and tgl_prev to hold the settled level.
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    unique case (state_q)
      StPrime: begin
        if (prime_cnt_q == PrimeW'(SYNC_STAGES)) begin
          state_d = StRun;
        end else begin
          prime_cnt_d = prime_cnt_q + PrimeW'(1);
        end
      end
      StRun: state_d = StRun;
      default: state_d = StPrime;
    endcase
  end

  // FSM output: edge detection is only enabled in run.
  always_comb begin
    tgl_edge = 1'b0;
    unique case (state_q)
      StPrime: tgl_edge = 1'b0;
      StRun:   tgl_edge = tgl_s ^ tgl_prev_q;
      default: tgl_edge = 1'b0;
    endcase
  end

  assign tgl_s     = sync_q[SYNC_STAGES-1];
  assign pop       = evt_valid & evt_ready;
  assign pend_full = &pending_q;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], tgl};
    tgl_prev_d = tgl_s;
    pulse_d    = tgl_edge;
    cnt_d      = cnt_q + (tgl_edge ? COUNT_W'(1) : COUNT_W'(0));
    pending_d  = pending_q;
    if (tgl_edge && !pop) begin
      if (!pend_full) pending_d = pending_q + PEND_W'(1);
    end else if (!tgl_edge && pop) begin
      pending_d = pending_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      tgl_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
      pending_q  <= '0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      tgl_prev_q <= tgl_prev_d;
      pulse_q    <= pulse_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef TOGGLE_DEC_OVF_EN
  logic ovf_q, ovf_d;

  // A pop always frees a slot, so only an unpopped edge into a full queue is a drop.
  always_comb begin
    ovf_d = ovf_q | (tgl_edge & ~pop & pend_full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign pulse     = pulse_q;
  assign pending   = pending_q;
  assign evt_valid = (pending_q != '0);
  assign evt_cnt   = cnt_q;

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Directed bench for toggle_pulse_decoder: default instance plus a PEND_W=2 instance for the
// saturation / drop case. Inputs change and outputs are sampled on the falling clock edge.
module tb_toggle_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tgl = 1'b0;
  logic       evt_ready = 1'b0;
  logic       pulse, evt_valid, ovf;
  logic [3:0] pending;
  logic [7:0] evt_cnt;

  logic       tgl2 = 1'b0;
  logic       evt_ready2 = 1'b0;
  logic       pulse2, evt_valid2, ovf2;
  logic [1:0] pending2;
  logic [7:0] evt_cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  toggle_pulse_decoder #(
    .SYNC_STAGES(2),
    .PEND_W     (4),
    .COUNT_W    (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tgl      (tgl),
    .pulse    (pulse),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .pending  (pending),
    .evt_cnt  (evt_cnt),
    .ovf      (ovf)
  );

  toggle_pulse_decoder #(
    .SYNC_STAGES(2),
    .PEND_W     (2),
    .COUNT_W    (8)
  ) dut_small (
    .clk      (clk),
    .rst      (rst),
    .tgl      (tgl2),
    .pulse    (pulse2),
    .evt_valid(evt_valid2),
    .evt_ready(evt_ready2),
    .pending  (pending2),
    .evt_cnt  (evt_cnt2),
    .ovf      (ovf2)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Reset both instances, release, then give them time to prime.
  task automatic reset_and_prime();
    @(negedge clk);
    rst        = 1'b1;
    evt_ready  = 1'b0;
    evt_ready2 = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(10);
  endtask

  task automatic test_reset();
    tgl = 1'b1;
    rst = 1'b1;
    tick(2);
    n_checks++;
    if ({pulse, evt_valid, pending, evt_cnt, ovf} !== 15'd0)
      $display("FAIL reset_outputs: got %b, want all zero",
               {pulse, evt_valid, pending, evt_cnt, ovf});
    else n_pass++;
    rst = 1'b0;
    // tgl=1 at release must not be mistaken for a change.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_checks++;
      if (pulse !== 1'b0) $display("FAIL prime_no_pulse cyc%0d: pulse=%b want 0", i, pulse);
      else n_pass++;
    end
    n_checks++;
    if (pending !== 4'd0 || evt_cnt !== 8'd0)
      $display("FAIL prime_counts: pending=%0d evt_cnt=%0d want 0/0", pending, evt_cnt);
    else n_pass++;
  endtask

  task automatic test_single_pulse();
    tgl = 1'b0;
    reset_and_prime();
    tgl = 1'b1;
    tick(1);  // after edge k
    n_checks++;
    if (pulse !== 1'b0) $display("FAIL latency_k: pulse=%b want 0", pulse);
    else n_pass++;
    tick(1);  // after edge k+1
    n_checks++;
    if (pulse !== 1'b0) $display("FAIL latency_k1: pulse=%b want 0", pulse);
    else n_pass++;
    tick(1);  // after edge k+2
    n_checks++;
    if (pulse !== 1'b1 || pending !== 4'd1 || evt_valid !== 1'b1 || evt_cnt !== 8'd1)
      $display("FAIL single_event: pulse=%b pending=%0d valid=%b cnt=%0d want 1/1/1/1",
               pulse, pending, evt_valid, evt_cnt);
    else n_pass++;
    tick(1);
    n_checks++;
    if (pulse !== 1'b0) $display("FAIL pulse_width: pulse=%b want 0", pulse);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp_p;
    reset_and_prime();
    for (int i = 0; i < 5; i++) begin
      tgl = ~tgl;
      tick(4);
    end
    n_checks++;
    if (pending !== 4'd5 || evt_cnt !== 8'd5)
      $display("FAIL queue_five: pending=%0d cnt=%0d want 5/5", pending, evt_cnt);
    else n_pass++;
    evt_ready = 1'b1;
    for (exp_p = 4; exp_p >= 0; exp_p--) begin
      tick(1);
      n_checks++;
      if (pending !== 4'(exp_p) || evt_valid !== (exp_p != 0))
        $display("FAIL drain_%0d: pending=%0d valid=%b want %0d/%b",
                 exp_p, pending, evt_valid, exp_p, exp_p != 0);
      else n_pass++;
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_pop_with_pulse();
    reset_and_prime();
    for (int i = 0; i < 3; i++) begin
      tgl = ~tgl;
      tick(4);
    end
    n_checks++;
    if (pending !== 4'd3) $display("FAIL pre_coincide: pending=%0d want 3", pending);
    else n_pass++;
    tgl = ~tgl;
    tick(2);
    evt_ready = 1'b1;  // pop lands on the same edge that registers the pulse
    tick(1);
    evt_ready = 1'b0;
    n_checks++;
    if (pulse !== 1'b1 || pending !== 4'd3 || evt_cnt !== 8'd4)
      $display("FAIL coincide: pulse=%b pending=%0d cnt=%0d want 1/3/4", pulse, pending, evt_cnt);
    else n_pass++;
  endtask

  task automatic test_saturate();
    logic exp_ovf;
`ifdef TOGGLE_DEC_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    reset_and_prime();
    for (int i = 0; i < 3; i++) begin
      tgl2 = ~tgl2;
      tick(4);
    end
    n_checks++;
    if (pending2 !== 2'd3 || ovf2 !== 1'b0)
      $display("FAIL sat_full: pending=%0d ovf=%b want 3/0", pending2, ovf2);
    else n_pass++;
    tgl2 = ~tgl2;
    tick(4);
    n_checks++;
    if (pending2 !== 2'd3 || evt_cnt2 !== 8'd4 || ovf2 !== exp_ovf)
      $display("FAIL sat_drop: pending=%0d cnt=%0d ovf=%b want 3/4/%b",
               pending2, evt_cnt2, ovf2, exp_ovf);
    else n_pass++;
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL ovf_idle_main: ovf=%b want 0", ovf);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    reset_and_prime();
    for (int i = 0; i < 7; i++) begin
      tgl = ~tgl;
      tick(4);
    end
    evt_ready = 1'b1;
    tick(5);
    evt_ready = 1'b0;
    n_checks++;
    if (pending !== 4'd2 || evt_cnt !== 8'd7)
      $display("FAIL pre_reset: pending=%0d cnt=%0d want 2/7", pending, evt_cnt);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({pulse, evt_valid, pending, evt_cnt, ovf} !== 15'd0)
      $display("FAIL async_reset: got %b, want all zero before clk edge",
               {pulse, evt_valid, pending, evt_cnt, ovf});
    else n_pass++;
    tick(1);
    rst = 1'b0;
    tick(10);
    tgl = ~tgl;
    tick(4);
    n_checks++;
    if (evt_cnt !== 8'd1 || pending !== 4'd1)
      $display("FAIL after_reset: cnt=%0d pending=%0d want 1/1", evt_cnt, pending);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_pop_with_pulse();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
